// File: rtl/seg_pkg.sv
// Shared digit codes, seven-segment patterns and BCD helpers for the display stage.
package seg_pkg;

    typedef logic [3:0] digit_t;

    localparam digit_t DIGIT_DASH  = 4'hA;
    localparam digit_t DIGIT_BLANK = 4'hF;

    localparam logic [31:0] MAX_DISPLAY = 32'd9999;

    // Active-low {dp,g,f,e,d,c,b,a}; dp is always off.
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic logic [7:0] seg_encode(input digit_t d);
        logic [7:0] s;
        case (d)
            4'h0:       s = SEG_0;
            4'h1:       s = SEG_1;
            4'h2:       s = SEG_2;
            4'h3:       s = SEG_3;
            4'h4:       s = SEG_4;
            4'h5:       s = SEG_5;
            4'h6:       s = SEG_6;
            4'h7:       s = SEG_7;
            4'h8:       s = SEG_8;
            4'h9:       s = SEG_9;
            DIGIT_DASH: s = SEG_DASH;
            default:    s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
    function automatic logic [15:0] bcd_adjust(input logic [15:0] b);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            if (b[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
            end else begin
                r[i*4 +: 4] = b[i*4 +: 4];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per cycle, done is high for one
// cycle while the result in bcd is final.
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int VALUE_W = 14
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [VALUE_W-1:0] bin,
    output logic               busy,
    output logic               done,
    output logic [15:0]        bcd
);

    localparam int SHIFT_W = 16 + VALUE_W;
    localparam int CNT_W   = $clog2(VALUE_W + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VALUE_W - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]         state_r;
    logic [SHIFT_W-1:0] shift_r;
    logic [SHIFT_W-1:0] step_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               busy_r;

    // One adjust-and-shift iteration over the {bcd, binary} working register.
    always_comb begin
        step_s = {bcd_adjust(shift_r[SHIFT_W-1:VALUE_W]), shift_r[VALUE_W-1:0]} << 1'b1;
    end

    // Conversion sequencer; busy rises on the first shift and drops on commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            shift_r <= {SHIFT_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        shift_r <= {16'h0000, bin};
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    busy_r  <= 1'b1;
                    shift_r <= step_s;
                    cnt_r   <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = (state_r == ST_DONE);
    assign bcd  = shift_r[SHIFT_W-1:VALUE_W];

endmodule

// File: rtl/seg_display_driver.sv
// Binary-to-BCD display stage driving a 4-digit common-anode seven-segment display.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module seg_display_driver
    import seg_pkg::*;
#(
    parameter int VALUE_W     = 14,
    parameter int REFRESH_DIV = 100000
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic [VALUE_W-1:0] value,
    input  logic               load,
    input  logic               blank,
    output logic               busy,
    output logic [7:0]         segs,
    output logic [3:0]         an
);

    localparam int REF_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [REF_W-1:0] REF_ONE  = REF_W'(1'b1);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);

    logic             pend_r;
    logic             ovf_r;
    logic             accept_s;
    logic             conv_busy_s;
    logic             conv_done_s;
    logic [15:0]      conv_bcd_s;
    logic [15:0]      digits_r;
    logic [REF_W-1:0] refresh_r;
    logic [1:0]       idx_r;
    logic [3:0]       an_r;
    logic [7:0]       segs_r;
    digit_t           raw_digit_s;
    digit_t           cur_digit_s;
`ifdef LEADING_ZERO_BLANK_EN
    logic [3:0]       lz_s;
`endif

    // pend_r covers the capture cycle before the converter raises busy.
    assign accept_s = load & ~conv_busy_s & ~pend_r;

    bin2bcd_seq #(
        .VALUE_W (VALUE_W)
    ) u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (accept_s),
        .bin   (value),
        .busy  (conv_busy_s),
        .done  (conv_done_s),
        .bcd   (conv_bcd_s)
    );

    // Load capture, overflow flag and atomic digit-register commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_r   <= 1'b0;
            ovf_r    <= 1'b0;
            digits_r <= 16'h0000;
        end else begin
            pend_r <= accept_s;
            if (accept_s) begin
                ovf_r <= (32'(value) > MAX_DISPLAY);
            end
            if (conv_done_s) begin
                digits_r <= ovf_r ? {4{DIGIT_DASH}} : conv_bcd_s;
            end
        end
    end

    // Select the digit for the current scan index, optionally hiding leading zeros.
    always_comb begin
        raw_digit_s = digits_r[{idx_r, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        lz_s[3] = (digits_r[15:12] == 4'd0);
        lz_s[2] = lz_s[3] & (digits_r[11:8] == 4'd0);
        lz_s[1] = lz_s[2] & (digits_r[7:4] == 4'd0);
        lz_s[0] = 1'b0;
        if (lz_s[idx_r]) begin
            cur_digit_s = DIGIT_BLANK;
        end else begin
            cur_digit_s = raw_digit_s;
        end
`else
        cur_digit_s = raw_digit_s;
`endif
    end

    // Refresh counter, digit index and registered anode/segment drive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refresh_r <= {REF_W{1'b0}};
            idx_r     <= 2'd0;
            an_r      <= 4'hF;
            segs_r    <= 8'hFF;
        end else begin
            if (refresh_r == REF_LAST) begin
                refresh_r <= {REF_W{1'b0}};
                idx_r     <= idx_r + 2'd1;
            end else begin
                refresh_r <= refresh_r + REF_ONE;
            end
            if (blank) begin
                an_r   <= 4'hF;
                segs_r <= 8'hFF;
            end else begin
                an_r   <= ~(4'b0001 << idx_r);
                segs_r <= seg_encode(cur_digit_s);
            end
        end
    end

    assign busy = conv_busy_s;
    assign an   = an_r;
    assign segs = segs_r;

endmodule

// File: tb/tb_seg_display_driver.sv
// Scoreboard bench for seg_display_driver (REFRESH_DIV=4): the stimulus side
// predicts every output change with its cycle number; a monitor pops and compares.
module tb_seg_display_driver;

    localparam int VALUE_W     = 14;
    localparam int REFRESH_DIV = 4;
    localparam int LAT         = VALUE_W + 1;

    logic               clk   = 1'b0;
    logic               reset = 1'b0;
    logic               load  = 1'b0;
    logic               blank = 1'b0;
    logic [VALUE_W-1:0] value = '0;
    logic               busy;
    logic [7:0]         segs;
    logic [3:0]         an;

    seg_display_driver #(
        .VALUE_W     (VALUE_W),
        .REFRESH_DIV (REFRESH_DIV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .value (value),
        .load  (load),
        .blank (blank),
        .busy  (busy),
        .segs  (segs),
        .an    (an)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [7:0] segs;
        logic       busy;
    } obs_t;

    obs_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Segment table written out by hand: digits 0..9, then DASH at index 10.
    logic [7:0] seg_tab [0:10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92,
                                   8'h82, 8'hF8, 8'h80, 8'h90, 8'hBF};

    // Reference model state
    int         m_ref, m_idx, m_t;
    bit         m_active;
    int         m_dig[4];
    int         m_pend[4];
    logic [3:0] m_an;
    logic [7:0] m_segs;
    logic       m_busy;

    function automatic logic [7:0] model_segs(int idx);
        logic [7:0] s;
`ifdef LEADING_ZERO_BLANK_EN
        bit lead;
`endif
        s = seg_tab[m_dig[idx]];
`ifdef LEADING_ZERO_BLANK_EN
        lead = (idx != 0);
        for (int j = idx; j < 4; j++) if (m_dig[j] != 0) lead = 1'b0;
        if (lead) s = 8'hFF;
`endif
        return s;
    endfunction

    task automatic model_clear();
        m_ref = 0; m_idx = 0; m_t = 0; m_active = 1'b0;
        for (int k = 0; k < 4; k++) m_dig[k] = 0;
    endtask

    task automatic expect_outputs(logic [3:0] a, logic [7:0] s, logic b, int at);
        obs_t e;
        if (a !== m_an || s !== m_segs || b !== m_busy) begin
            e.cyc = at; e.an = a; e.segs = s; e.busy = b;
            exp_q.push_back(e);
        end
        m_an = a; m_segs = s; m_busy = b;
    endtask

    // Advance the model across the next rising edge, then take that edge.
    task automatic tick();
        logic [3:0] n_an;
        logic [7:0] n_segs;
        logic       n_busy;
        int         v;
        if (reset) begin
            model_clear();
        end else begin
            if (blank) begin
                n_an = 4'hF; n_segs = 8'hFF;
            end else begin
                n_an = ~(4'b0001 << m_idx); n_segs = model_segs(m_idx);
            end
            n_busy = m_busy;
            if (m_active) begin
                m_t++;
                if (m_t == 1) n_busy = 1'b1;
                if (m_t == LAT) begin
                    m_dig = m_pend; n_busy = 1'b0; m_active = 1'b0;
                end
            end else if (load) begin
                m_active = 1'b1; m_t = 0;
                if (value > 14'd9999) begin
                    for (int k = 0; k < 4; k++) m_pend[k] = 10;
                end else begin
                    v = int'(value);
                    for (int k = 0; k < 4; k++) begin m_pend[k] = v % 10; v = v / 10; end
                end
            end
            if (m_ref == REFRESH_DIV - 1) begin
                m_ref = 0; m_idx = (m_idx + 1) % 4;
            end else begin
                m_ref++;
            end
            expect_outputs(n_an, n_segs, n_busy, cyc + 1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic issue_load(logic [VALUE_W-1:0] v);
        value = v; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // Asynchronous reset pulse: outputs must clear before the next clock edge.
    task automatic reset_pulse();
        reset = 1'b1;
        expect_outputs(4'hF, 8'hFF, 1'b0, cyc);
        model_clear();
        run(2);
        reset = 1'b0;
    endtask

    // Monitor: every change on {an, segs, busy} is one DUT output event.
    initial begin : monitor
        logic [3:0] p_an;
        logic [7:0] p_segs;
        logic       p_busy;
        obs_t       e;
        p_an = 4'hF; p_segs = 8'hFF; p_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (an !== p_an || segs !== p_segs || busy !== p_busy) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change: cyc=%0d an=%b segs=%h busy=%b, no change required",
                             cyc, an, segs, busy);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.an !== an || e.segs !== segs || e.busy !== busy) begin
                        n_fail++;
                        $display("FAIL scoreboard: got cyc=%0d an=%b segs=%h busy=%b, required cyc=%0d an=%b segs=%h busy=%b",
                                 cyc, an, segs, busy, e.cyc, e.an, e.segs, e.busy);
                    end
                end
                p_an = an; p_segs = segs; p_busy = busy;
            end
        end
    end

    initial begin : stimulus
        m_an = 4'hF; m_segs = 8'hFF; m_busy = 1'b0;
        model_clear();
        #1 reset = 1'b1;
        run(2);
        n_checks++;
        if (an !== 4'hF || segs !== 8'hFF || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got an=%b segs=%h busy=%b, required an=1111 segs=ff busy=0",
                     an, segs, busy);
        end
        reset = 1'b0;
        run(20);                      // idle scan of "0000"

        issue_load(14'd1234);
        run(30);

        value = 14'd16; load = 1'b1;  // second request lands while first is pending
        tick();
        value = 14'd5;
        tick();
        load = 1'b0;
        run(30);

        issue_load(14'd10000);        // overflow -> dashes
        run(30);

        issue_load(14'd9999);         // largest displayable value
        run(30);

        blank = 1'b1;
        run(10);
        blank = 1'b0;
        run(12);

        issue_load(14'd4321);
        run(7);
        reset_pulse();                // abort mid-conversion
        run(20);

        issue_load(14'd7);
        run(30);

        issue_load(14'd0);
        run(30);

        run(4);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_changes: got %0d unmatched events, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
